unit_group_scheduler: RTL and testbench

- Sequences a group of NUM_UNITS child units, by default five instances, that share one downstream resource slot.
- Each unit raises req. The scheduler grants exactly one unit at a time in round-robin order, pulses start to it, and holds the grant until that unit's done.
- Sits in the parent module alongside the child instances; all child req/done lines are wired to it.

---
 rtl/unit_group_scheduler_pkg.sv | 25 ++
 rtl/unit_group_scheduler_if.sv | 38 +++
 rtl/unit_group_scheduler_rr_pick.sv | 43 ++++
 rtl/unit_group_scheduler.sv | 149 ++++++++++++++
 tb/tb_unit_group_scheduler.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/unit_group_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// unit_sched_pkg
// Shared types and defaults for the unit group scheduler.
//   sched_state_e : scheduler FSM states (IDLE, RUN)
//   DEF_*         : default parameter values
//   onehot_of()   : unit index -> one-hot vector (up to MAX_UNITS units)
// Optional feature macro used by the scheduler: UNIT_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package unit_sched_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   localparam int DEF_NUM_UNITS      = 5;
   localparam int DEF_TIMEOUT_CYCLES = 64;
   localparam int MAX_UNITS          = 16;
   localparam int MAX_ID_W           = 4;

   function automatic logic [MAX_UNITS-1:0] onehot_of(input logic [MAX_ID_W-1:0] id);
      onehot_of = MAX_UNITS'(1) << id;
   endfunction

endpackage

// File: rtl/unit_group_scheduler_if.sv
// -----------------------------------------------------------------------------
// unit_group_scheduler_if
// Request/grant bundle between the scheduler and its child units.
//   enable      : permits new grants
//   req         : per-unit request level
//   done        : per-unit completion pulse
//   grant       : one-hot grant, held for the whole job
//   start       : single-cycle pulse on the first granted cycle
//   cur_id      : index of the granted unit, valid while busy
//   busy        : a job is running
//   timeout_err : single-cycle watchdog expiry pulse
// Modports: master = scheduler side, slave = parent/unit side.
// -----------------------------------------------------------------------------
interface unit_group_scheduler_if
   import unit_sched_pkg::*;
#(
   parameter int NUM_UNITS = DEF_NUM_UNITS,
   parameter int ID_W      = $clog2(NUM_UNITS)
);
   logic                 enable;
   logic [NUM_UNITS-1:0] req;
   logic [NUM_UNITS-1:0] done;
   logic [NUM_UNITS-1:0] grant;
   logic                 start;
   logic [ID_W-1:0]      cur_id;
   logic                 busy;
   logic                 timeout_err;

   modport master (
      input  enable, req, done,
      output grant, start, cur_id, busy, timeout_err
   );

   modport slave (
      output enable, req, done,
      input  grant, start, cur_id, busy, timeout_err
   );
endinterface

// File: rtl/unit_group_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req starting at last+1,
// wrapping explicitly at NUM_UNITS so indices >= NUM_UNITS never appear.
//   req   : request vector
//   last  : index served most recently
//   found : at least one request is set
//   idx   : first requesting index after last
// -----------------------------------------------------------------------------
module rr_pick
   import unit_sched_pkg::*;
#(
   parameter int NUM_UNITS = DEF_NUM_UNITS,
   parameter int ID_W      = $clog2(NUM_UNITS)
) (
   input  logic [NUM_UNITS-1:0] req,
   input  logic [ID_W-1:0]      last,
   output logic                 found,
   output logic [ID_W-1:0]      idx
);

   // One extra bit so last+i (at most 2*NUM_UNITS-1) cannot overflow.
   localparam logic [ID_W:0] LIMIT = (ID_W+1)'(NUM_UNITS);

   logic [ID_W:0] cand;

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_UNITS; i++) begin
         cand = {1'b0, last} + (ID_W+1)'(i);
         if (cand >= LIMIT) cand = cand - LIMIT;
         if (!found && req[cand[ID_W-1:0]]) begin
            found = 1'b1;
            idx   = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/unit_group_scheduler.sv
// -----------------------------------------------------------------------------
// unit_group_scheduler
// Grants one of NUM_UNITS child units at a time in round-robin order, pulses
// start on the first granted cycle and holds the grant until that unit's done.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : unit_group_scheduler_if.master (enable, req, done in;
//           grant, start, cur_id, busy, timeout_err out)
// Optional feature macro: UNIT_SCHED_TIMEOUT_EN -- adds a RUN-state watchdog
// of TIMEOUT_CYCLES cycles; without it timeout_err is tied low.
// -----------------------------------------------------------------------------
module unit_group_scheduler
   import unit_sched_pkg::*;
#(
   parameter int NUM_UNITS      = DEF_NUM_UNITS,
   parameter int ID_W           = $clog2(NUM_UNITS),
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   unit_group_scheduler_if.master  bus
);

   if (NUM_UNITS < 2 || NUM_UNITS > MAX_UNITS || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("unit_group_scheduler: NUM_UNITS must be 2..16 and TIMEOUT_CYCLES >= 2");
   end

   // Pointer starts at the top index so unit 0 wins the first arbitration.
   localparam logic [ID_W-1:0] LAST_RESET = ID_W'(NUM_UNITS - 1);

   sched_state_e         state_q, state_d;
   logic [NUM_UNITS-1:0] grant_q, grant_d;
   logic [ID_W-1:0]      cur_id_q, cur_id_d;
   logic [ID_W-1:0]      last_q, last_d;
   logic                 start_q, start_d;
   logic                 busy_q, busy_d;
   logic                 pick_found;
   logic [ID_W-1:0]      pick_id;
   logic                 job_done;

`ifdef UNIT_SCHED_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`endif

   rr_pick #(
      .NUM_UNITS (NUM_UNITS),
      .ID_W      (ID_W)
   ) u_pick (
      .req   (bus.req),
      .last  (last_q),
      .found (pick_found),
      .idx   (pick_id)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         cur_id_q  <= '0;
         last_q    <= LAST_RESET;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UNIT_SCHED_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cur_id_q  <= cur_id_d;
         last_q    <= last_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
`ifdef UNIT_SCHED_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cur_id_d  = cur_id_q;
      last_d    = last_q;
      start_d   = 1'b0;
      busy_d    = busy_q;
      job_done  = 1'b0;
`ifdef UNIT_SCHED_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.enable && pick_found) begin
               state_d  = RUN;
               grant_d  = NUM_UNITS'(onehot_of(MAX_ID_W'(pick_id)));
               cur_id_d = pick_id;
               start_d  = 1'b1;
               busy_d   = 1'b1;
`ifdef UNIT_SCHED_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         RUN: begin
            // done is ignored on the start cycle; only the granted unit counts.
            job_done = !start_q && bus.done[cur_id_q];
            if (job_done) begin
               state_d = IDLE;
               grant_d = '0;
               busy_d  = 1'b0;
               last_d  = cur_id_q;
            end
`ifdef UNIT_SCHED_TIMEOUT_EN
            // A done arriving on the expiry cycle takes priority over the watchdog.
            else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               grant_d   = '0;
               busy_d    = 1'b0;
               last_d    = cur_id_q;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.grant  = grant_q;
   assign bus.start  = start_q;
   assign bus.cur_id = cur_id_q;
   assign bus.busy   = busy_q;
`ifdef UNIT_SCHED_TIMEOUT_EN
   assign bus.timeout_err = timeout_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_unit_group_scheduler.sv
// -----------------------------------------------------------------------------
// tb_unit_group_scheduler
// Self-checking bench for unit_group_scheduler (NUM_UNITS = 5). A job-level
// model (owner / job age / last served) predicts grant, start, busy, cur_id and
// timeout_err every cycle; directed sequences add literal expectations.
// Timeout sequences are compiled in when UNIT_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_unit_group_scheduler;
   import unit_sched_pkg::*;

   localparam int N = 5;
`ifdef UNIT_SCHED_TIMEOUT_EN
   localparam int TO         = 8;
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam int TO         = 64;
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   logic clk;
   logic rst_n;

   unit_group_scheduler_if #(.NUM_UNITS(N)) bus ();

   unit_group_scheduler #(
      .NUM_UNITS      (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   bit cmp_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int id_of(input logic [N-1:0] g);
      id_of = -1;
      for (int i = 0; i < N; i++) if (g[i]) id_of = i;
   endfunction

   // ---------------- job-level model ----------------
   int owner    = -1;   // unit holding the slot, -1 when free
   int age      = 0;    // cycles since the grant was issued
   int last_srv = N-1;  // most recently finished unit
   bit exp_err  = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner    = -1;
         age      = 0;
         last_srv = N-1;
         exp_err  = 1'b0;
      end else begin
         exp_err = 1'b0;
         if (owner < 0) begin
            if (bus.enable && (bus.req != '0)) begin
               for (int k = 1; k <= N; k++) begin
                  int c;
                  c = (last_srv + k) % N;
                  if (owner < 0 && bus.req[c]) owner = c;
               end
               age = 0;
            end
         end else if (age > 0 && bus.done[owner]) begin
            last_srv = owner;
            owner    = -1;
         end else if (TIMEOUT_ON && age == TO-1) begin
            exp_err  = 1'b1;
            last_srv = owner;
            owner    = -1;
         end else begin
            age++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         logic [N-1:0] eg;
         eg = (owner >= 0) ? N'(1 << owner) : '0;
         check("grant",       bus.grant,       eg);
         check("start",       bus.start,       (owner >= 0 && age == 0));
         check("busy",        bus.busy,        (owner >= 0));
         check("timeout_err", bus.timeout_err, exp_err);
         if (owner >= 0) check("cur_id", bus.cur_id, owner);
      end
   end

   // ---------------- helpers ----------------
   task automatic apply_reset();
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.req    = '0;
      bus.done   = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (bus.start === 1'b1) ok = 1'b1;
      end
      check("start_seen", ok, 1);
   endtask

   task automatic finish_job(input logic [N-1:0] new_req);
      @(posedge clk);
      #2 bus.done = bus.grant;
      bus.req = new_req;
      @(posedge clk);
      #2 bus.done = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- directed sequences ----------------
   initial begin
      bit ok;
      int t0;
      int prev;
      int exp_order [6] = '{0, 1, 2, 3, 4, 0};

      rst_n      = 1'b1;
      bus.enable = 1'b0;
      bus.req    = '0;
      bus.done   = '0;
      #1;
      apply_reset();
      check("rst_grant",   bus.grant,       0);
      check("rst_start",   bus.start,       0);
      check("rst_busy",    bus.busy,        0);
      check("rst_cur_id",  bus.cur_id,      0);
      check("rst_timeout", bus.timeout_err, 0);
      cmp_en = 1'b1;

      // Single request: one-cycle grant latency, release after done.
      bus.enable = 1'b1;
      bus.req    = 5'b00001;
      @(posedge clk);
      #1 check("t1_grant", bus.grant, 5'b00001);
      check("t1_start", bus.start, 1);
      @(posedge clk);
      #2 bus.done = 5'b00001;
      bus.req = '0;
      @(posedge clk);
      #1 check("t1_release_grant", bus.grant, 0);
      check("t1_release_busy", bus.busy, 0);
      #1 bus.done = '0;

      // All requesting: order 0,1,2,3,4,0 with a 3-cycle grant-to-grant spacing.
      apply_reset();
      bus.enable = 1'b1;
      bus.req    = 5'b11111;
      prev       = 0;
      for (int j = 0; j < 6; j++) begin
         wait_start(20, ok);
         check("rr_order", id_of(bus.grant), exp_order[j]);
         if (j > 0) check("grant_gap", cyc - prev, 3);
         prev = cyc;
         finish_job((j == 5) ? 5'b00000 : 5'b11111);
      end

      // Foreign done and done on the start cycle are ignored; req drop keeps grant.
      bus.req = 5'b00100;
      wait_start(10, ok);
      check("t3_pick", id_of(bus.grant), 2);
      bus.req  = '0;
      bus.done = 5'b00100;
      @(posedge clk);
      #2 bus.done = 5'b01001;
      @(posedge clk);
      #2 bus.done = '0;
      @(negedge clk);
      check("t3_hold_grant", bus.grant, 5'b00100);
      bus.done = 5'b00100;
      @(posedge clk);
      #2 bus.done = '0;
      @(negedge clk);
      check("t3_release", bus.grant, 0);

      // enable dropped mid-job: job completes, no new grant until re-enabled.
      bus.enable = 1'b1;
      bus.req    = 5'b11111;
      wait_start(10, ok);
      check("t4_pick", id_of(bus.grant), 3);
      bus.enable = 1'b0;
      finish_job(5'b11111);
      repeat (6) @(negedge clk);
      check("t4_idle_disabled", bus.busy, 0);
      bus.enable = 1'b1;
      wait_start(5, ok);
      check("t4_resume_pick", id_of(bus.grant), 4);
      finish_job(5'b00000);

      // Reset while busy: outputs clear asynchronously, pointer restored.
      bus.req = 5'b11111;
      wait_start(10, ok);
      check("t5_wrap_pick", id_of(bus.grant), 0);
      #2 rst_n = 1'b0;
      #1 check("t5_async_grant", bus.grant, 0);
      check("t5_async_start", bus.start, 0);
      check("t5_async_busy",  bus.busy,  0);
      bus.req = 5'b10000;
      @(posedge clk);
      #2 rst_n = 1'b1;
      wait_start(5, ok);
      check("t5_after_reset_pick", id_of(bus.grant), 4);
      finish_job(5'b00000);

`ifdef UNIT_SCHED_TIMEOUT_EN
      // Watchdog expiry, then done landing exactly on the expiry cycle.
      apply_reset();
      bus.enable = 1'b1;
      bus.req    = 5'b00011;
      wait_start(10, ok);
      check("to_pick", id_of(bus.grant), 0);
      t0 = cyc;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (bus.timeout_err === 1'b1) ok = 1'b1;
      end
      check("to_seen", ok, 1);
      check("to_latency", cyc - t0, TO);
      check("to_grant_drop", bus.grant, 0);
      wait_start(5, ok);
      check("to_next_pick", id_of(bus.grant), 1);
      repeat (TO-1) @(negedge clk);
      bus.done = 5'b00010;
      @(posedge clk);
      #2 bus.done = '0;
      bus.req = '0;
      @(negedge clk);
      check("to_done_wins_err", bus.timeout_err, 0);
      check("to_done_wins_busy", bus.busy, 0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
